// File: rtl/mac_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// Package: ABC_parameter
//
// Shared parameters for the multiply-add pipeline and its accumulator stage.
//   WIDTH        operand width of the a*b+c stage; its product is 2*WIDTH bits
//   N_ACC        default number of samples summed into one accumulator result
//   acc_state_t  accumulator FSM state: ACC (summing) / FULL (result pending)
// ---------------------------------------------------------------------------
package ABC_parameter;

    localparam int WIDTH = 8;
    localparam int N_ACC = 4;

    typedef enum logic {
        ACC  = 1'b0,
        FULL = 1'b1
    } acc_state_t;

endpackage : ABC_parameter

// File: rtl/mac_accumulator.sv
// ---------------------------------------------------------------------------
// Module: mac_accumulator
//
// Sums N_ACC consecutive accepted product samples from the multiply-add stage
// and presents each sum on a valid/ready output. A pending result stalls the
// input only while the consumer is not taking it; a handoff and a new accept
// can share one cycle, so throughput is one sample per clock.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low; clears all state
//   clear      in   synchronous abort of the partial sum and any pending result
//   in_valid   in   in_data is valid this cycle
//   in_data    in   2*WIDTH-bit product sample
//   in_ready   out  sample is accepted at this edge if in_valid is also high
//   out_valid  out  out_data holds a completed sum
//   out_data   out  OW-bit sum of N_ACC samples
//   out_ready  in   consumer takes out_data this cycle
//   busy       out  partial sum in progress
// ---------------------------------------------------------------------------
module mac_accumulator
    import ABC_parameter::*;
#(
    parameter int WIDTH = ABC_parameter::WIDTH,
    parameter int N_ACC = ABC_parameter::N_ACC
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  clear,
    input  logic                                  in_valid,
    input  logic [2*WIDTH-1:0]                    in_data,
    output logic                                  in_ready,
    output logic                                  out_valid,
    output logic [2*WIDTH+$clog2(N_ACC)-1:0]      out_data,
    input  logic                                  out_ready,
    output logic                                  busy
);

    // Result width: N_ACC * (2^(2*WIDTH) - 1) always fits, so adds never wrap.
    localparam int OW = 2*WIDTH + $clog2(N_ACC);
    localparam int CW = $clog2(N_ACC);

    localparam logic [CW-1:0] CNT_LAST = CW'(N_ACC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    acc_state_t    state_q, state_d;
    logic [OW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;

    logic [OW-1:0] sample_ext;
    logic          accept;

    assign sample_ext = OW'(in_data);

    // In FULL the input is open only when the pending result leaves this cycle,
    // which is what lets a handoff and a new accept share one edge.
    assign in_ready = !clear && ((state_q == ACC) || out_ready);
    assign accept   = in_valid && in_ready;

    // NOTE: every always_comb output gets a default first so that no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (clear) begin
            state_d     = ACC;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ACC: begin
                    if (accept) begin
                        if (cnt_q == CNT_LAST) begin
                            out_data_d  = acc_q + sample_ext;
                            out_valid_d = 1'b1;
                            acc_d       = '0;
                            cnt_d       = '0;
                            state_d     = FULL;
                        end else begin
                            acc_d = acc_q + sample_ext;
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ACC;
                        // Sample accepted alongside the handoff starts the next sum.
                        if (in_valid) begin
                            acc_d = sample_ext;
                            cnt_d = CNT_ONE;
                        end
                    end
                end
                default: state_d = ACC;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (cnt_q != '0);

endmodule : mac_accumulator

// File: tb/tb_mac_accumulator.sv
// ---------------------------------------------------------------------------
// Testbench: tb_mac_accumulator
//
// Table of four-sample groups with their expected sums, plus directed
// sequences for back-pressure, clear and mid-operation reset. Expected sums
// are queued when a group's last sample is sent and compared by a monitor
// whenever the DUT hands a result off (out_valid && out_ready).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_mac_accumulator;

    localparam int WIDTH = 8;
    localparam int N_ACC = 4;
    localparam int OW    = 2*WIDTH + $clog2(N_ACC);

    logic                 clk;
    logic                 reset;
    logic                 clear;
    logic                 in_valid;
    logic [2*WIDTH-1:0]   in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic [OW-1:0]        out_data;
    logic                 out_ready;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_q[$];

    typedef struct packed {
        logic [3:0][15:0] s;
        logic [31:0]      sum;
    } vec_t;

    vec_t vecs[5];

    mac_accumulator #(
        .WIDTH (WIDTH),
        .N_ACC (N_ACC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int a, input int b, input int c, input int d, input int sum);
        vec_t v;
        v.s[0] = 16'(a);
        v.s[1] = 16'(b);
        v.s[2] = 16'(c);
        v.s[3] = 16'(d);
        v.sum  = 32'(sum);
        return v;
    endfunction

    // Scoreboard monitor: every handoff must match the oldest queued sum.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                check("result_data", 32'(out_data), sb_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until it is accepted (bounded).
    task automatic send(input logic [15:0] d);
        bit taken;
        taken    = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50 && !taken; i++) begin
            @(negedge clk);
            taken = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!taken) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_group(input vec_t v);
        for (int i = 0; i < 4; i++) send(v.s[i]);
        sb_q.push_back(v.sum);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = mk(10, 20, 30, 40, 100);
        vecs[1] = mk(65025, 65025, 65025, 65025, 260100);
        vecs[2] = mk(0, 0, 0, 0, 0);
        vecs[3] = mk(1, 2, 3, 4, 10);
        vecs[4] = mk(65535, 0, 65535, 1, 131071);

        // 1: reset held with random inputs
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clear     = 1'($urandom);
            in_valid  = 1'($urandom);
            in_data   = 16'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data",  32'(out_data),  32'd0);
            check("rst_busy",      32'(busy),      32'd0);
            check("rst_in_ready",  32'(in_ready),  32'(!clear));
        end
        step();
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        reset     = 1'b1;
        step();
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // 2: single group, out_valid for exactly one cycle
        send_group(vecs[0]);
        check("t2_out_valid_rise", 32'(out_valid), 32'd1);
        check("t2_out_data",       32'(out_data),  32'd100);
        check("t2_busy_full",      32'(busy),      32'd0);
        step();
        check("t2_out_valid_fall", 32'(out_valid), 32'd0);
        check("t2_out_data_kept",  32'(out_data),  32'd100);

        // Table: groups back-to-back, first sample of each lands on the handoff edge
        for (int v = 0; v < 5; v++) send_group(vecs[v]);
        step();
        check("tbl_drained", 32'(out_valid), 32'd0);

        // 4: back-pressure hold, then same-edge handoff plus accept
        out_ready = 1'b0;
        send_group(vecs[0]);
        in_valid = 1'b1;
        in_data  = 16'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_hold_in_ready",  32'(in_ready),  32'd0);
            check("t4_hold_out_valid", 32'(out_valid), 32'd1);
            check("t4_hold_out_data",  32'(out_data),  32'd100);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_release_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("t4_handoff_out_valid", 32'(out_valid), 32'd0);
        check("t4_handoff_busy",      32'(busy),      32'd1);
        send(16'd6);
        send(16'd7);
        send(16'd8);
        sb_q.push_back(32'd26);
        check("t4_sum_after_handoff", 32'(out_valid), 32'd1);
        step();

        // 5: clear aborts a partial sum and blocks the concurrent sample
        send(16'd7);
        send(16'd9);
        check("t5_busy_before", 32'(busy), 32'd1);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd50;
        @(negedge clk);
        check("t5_clear_in_ready", 32'(in_ready), 32'd0);
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("t5_clear_busy", 32'(busy), 32'd0);
        send_group(mk(1, 1, 1, 1, 4));
        step();

        // clear also drops a pending result
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'd3);
        check("t5_pending_valid", 32'(out_valid), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t5_dropped_valid", 32'(out_valid), 32'd0);
        check("t5_dropped_data",  32'(out_data),  32'd12);
        out_ready = 1'b1;

        // 6: asynchronous reset between edges after two samples
        send(16'd3);
        send(16'd3);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_async_busy",      32'(busy),      32'd0);
        check("t6_async_out_data",  32'(out_data),  32'd0);
        check("t6_async_out_valid", 32'(out_valid), 32'd0);
        check("t6_async_in_ready",  32'(in_ready),  32'd1);
        #1;
        reset = 1'b1;
        step();
        send_group(mk(2, 2, 2, 2, 8));
        check("t6_out_data", 32'(out_data), 32'd8);
        step();
        step();

        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mac_accumulator
